// File: rtl/arb_pkg.sv
// Shared definitions for the request arbiter.
//   arb_state_e      : arbiter FSM encoding (IDLE / GRANT / GAP)
//   ARB_N_DEF        : default number of requesters
//   ARB_MAX_HOLD_DEF : default maximum consecutive grant cycles
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational pick-highest-set over an N-bit vector.
// Ports:
//   req_vec  in  N     candidate vector
//   pick_oh  out N     one-hot of the highest set bit (0 if none)
//   pick_idx out ID_W  binary index of that bit (0 if none)
//   pick_any out 1     any bit set
module arb_prio_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_vec,
    output logic [N-1:0]    pick_oh,
    output logic [ID_W-1:0] pick_idx,
    output logic            pick_any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_vec[i]) begin
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
                pick_idx   = ID_W'(i);
                pick_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Sequential N-way arbiter: registered one-hot grant held until the owner
// releases, withdraws, or the hold limit expires; then one GAP cycle.
// Optional macro REQ_ARBITER_RR_EN selects round-robin winner selection;
// without it, the highest asserted index wins.
// Ports:
//   clk       in  1     rising-edge clock
//   rst_n     in  1     asynchronous active-low reset
//   req       in  N     request levels, bit i = requester i
//   release_i in  1     owner done (sampled only while a grant is active)
//   gnt       out N     registered one-hot grant, 0 when idle
//   gnt_id    out ID_W  index of granted requester, 0 when idle
//   gnt_vld   out 1     grant active (|gnt)
//   timeout   out 1     one-cycle pulse after a hold-limit revocation
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int ID_W     = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            release_i,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);

    localparam int              CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     pick_in, pick_oh, win_oh;
    logic [ID_W-1:0]  pick_idx, win_id;
    logic             pick_any;
    logic             owner_done, hold_at_lim;

    arb_prio_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req_vec  (pick_in),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

`ifdef REQ_ARBITER_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] rr_src;

    // Bit j of the picker input carries requester (ptr+N-j) mod N, so the
    // picker's top bit is ptr+1 and descending bits follow ptr+2, ptr+3...
    // The same mapping rotates the one-hot and the index back.
    always_comb begin
        pick_in = '0;
        win_oh  = '0;
        rr_src  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            rr_src          = ID_W'((32'(ptr_q) + N - j) % N);
            pick_in[j]      = req[rr_src];
            win_oh[rr_src]  = pick_oh[j];
        end
        win_id = ID_W'((32'(ptr_q) + N - 32'(pick_idx)) % N);
    end
`else
    always_comb begin
        pick_in = req;
        win_oh  = pick_oh;
        win_id  = pick_idx;
    end
`endif

    // A withdrawn request ends the grant exactly like a release.
    assign owner_done  = release_i | ~req[gnt_id_q];
    assign hold_at_lim = (hold_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
`ifdef REQ_ARBITER_RR_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d    = win_oh;
                    gnt_id_d = win_id;
                    hold_d   = '0;
                    state_d  = GRANT;
`ifdef REQ_ARBITER_RR_EN
                    ptr_d    = win_id;
`endif
                end
            end
            GRANT: begin
                if (owner_done || hold_at_lim) begin
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    state_d   = GAP;
                    // Release (or withdrawal) takes precedence over the limit.
                    timeout_d = hold_at_lim & ~owner_done;
                end else begin
                    // Exiting at the limit keeps the counter from ever wrapping.
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef REQ_ARBITER_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(N - 2);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = |gnt_q;
    assign timeout = timeout_q;

endmodule
